// File: rtl/boot_link_pkg.sv
// rtl/boot_link_pkg.sv - shared sizes and sequencer state encoding for the boot host link
package boot_link_pkg;
   localparam int WORDS  = 64;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LD_FETCH,
      LD_HI,
      LD_LO,
      SC_HI,
      SC_LO,
      SC_WRITE,
      FINISH
   } state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with go/ready handshake
module uart_tx_byte
   import boot_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              go,
   input  logic [BYTE_W-1:0] data,
   output logic              ready,
   output logic              tx
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic              active;
   logic [TW-1:0]     tmr;
   logic [3:0]        idx;
   logic [BYTE_W:0]   sh;
   logic              bit_end;

   assign bit_end = active && (tmr == LAST);
   // Ready in the last stop-bit cycle too, so a following byte starts with no idle gap.
   assign ready   = !active || (bit_end && idx == 4'd9);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active <= 1'b0;
         tmr    <= '0;
         idx    <= '0;
         sh     <= '0;
         tx     <= 1'b1;
      end else if (ce) begin
         if (ready && go) begin
            active <= 1'b1;
            tmr    <= '0;
            idx    <= '0;
            sh     <= {1'b1, data};
            tx     <= 1'b0;
         end else if (bit_end) begin
            tmr <= '0;
            if (idx == 4'd9) begin
               active <= 1'b0;
            end else begin
               tx  <= sh[0];
               sh  <= {1'b1, sh[BYTE_W:1]};
               idx <= idx + 4'd1;
            end
         end else if (active) begin
            tmr <= tmr + TW'(1);
         end
      end
   end
endmodule

// File: rtl/boot_host_link.sv
// rtl/boot_host_link.sv - streams the image ROM to the CPU and captures its memory dump
module boot_host_link
   import boot_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              start,
   input  logic              op,
   output logic [ADDR_W-1:0] img_adr,
   input  logic [DATA_W-1:0] img_data,
   output logic              tx,
   input  logic              rx,
   output logic              dump_we,
   output logic [ADDR_W-1:0] dump_adr,
   output logic [DATA_W-1:0] dump_data,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]     FULL_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]     HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [BYTE_W-1:0] lo_byte, hi_byte, tx_byte, rx_sh;
   logic              tx_go, tx_ready;
   logic              rx_s1, rx_s2, rx_prev, rx_busy, rx_sample, rx_byte_done;
   logic [TW-1:0]     rx_tmr;
   logic [3:0]        rx_idx;

   assign img_adr      = cnt;
   assign tx_go        = (state == LD_FETCH) || (state == LD_HI && tx_ready);
   assign tx_byte      = (state == LD_FETCH) ? img_data[DATA_W-1 -: BYTE_W] : lo_byte;
   assign rx_sample    = rx_busy && (rx_tmr == ((rx_idx == 4'd0) ? HALF_LAST : FULL_LAST));
   assign rx_byte_done = rx_sample && (rx_idx == 4'd9);

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .go    (tx_go),
      .data  (tx_byte),
      .ready (tx_ready),
      .tx    (tx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lo_byte   <= '0;
         hi_byte   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         dump_we   <= 1'b0;
         dump_adr  <= '0;
         dump_data <= '0;
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_busy   <= 1'b0;
         rx_tmr    <= '0;
         rx_idx    <= '0;
         rx_sh     <= '0;
      end else if (ce) begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;

         // Receiver runs only during scan; the stop sample flags err but the byte is kept.
         if (state inside {SC_HI, SC_LO, SC_WRITE}) begin
            if (!rx_busy) begin
               if (rx_prev && !rx_s2) begin
                  rx_busy <= 1'b1;
                  rx_tmr  <= '0;
                  rx_idx  <= '0;
               end
            end else if (rx_sample) begin
               rx_tmr <= '0;
               if (rx_idx == 4'd0) begin
                  if (rx_s2) rx_busy <= 1'b0;
                  else       rx_idx  <= 4'd1;
               end else if (rx_idx == 4'd9) begin
                  rx_busy <= 1'b0;
                  if (!rx_s2) err <= 1'b1;
               end else begin
                  rx_sh  <= {rx_s2, rx_sh[BYTE_W-1:1]};
                  rx_idx <= rx_idx + 4'd1;
               end
            end else begin
               rx_tmr <= rx_tmr + TW'(1);
            end
         end else begin
            rx_busy <= 1'b0;
         end

         case (state)
            IDLE: if (start) begin
               busy  <= 1'b1;
               err   <= 1'b0;
               cnt   <= '0;
               state <= op ? SC_HI : LD_FETCH;
            end
            LD_FETCH: begin
               lo_byte <= img_data[BYTE_W-1:0];
               state   <= LD_HI;
            end
            LD_HI: if (tx_ready) state <= LD_LO;
            LD_LO: if (tx_ready) begin
               if (cnt == LAST_WORD) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt   <= cnt + ADDR_W'(1);
                  state <= LD_FETCH;
               end
            end
            SC_HI: if (rx_byte_done) begin
               hi_byte <= rx_sh;
               state   <= SC_LO;
            end
            SC_LO: if (rx_byte_done) begin
               dump_we   <= 1'b1;
               dump_adr  <= cnt;
               dump_data <= {hi_byte, rx_sh};
               state     <= SC_WRITE;
            end
            SC_WRITE: begin
               dump_we <= 1'b0;
               if (cnt == LAST_WORD) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt   <= cnt + ADDR_W'(1);
                  state <= SC_HI;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
